// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ctrl
// Purpose  : Sequences ratio changes for a downstream clock divider. Each
//            update step presents the new ratio, holds the enable strobe for
//            EN_HOLD cycles, then waits SETTLE_CYC cycles before committing
//            the ratio. Ramp mode walks the ratio one unit per step toward
//            the target; jump mode applies the target in a single step.
// Ports    : i_clk_ref     - reference clock (shared with the divider)
//            i_rst_n       - asynchronous active-low reset
//            i_req         - request level, accepted only while idle
//            i_div_num     - target ratio (0 is treated as 1)
//            i_ramp        - 1 = ramp by single units, 0 = single jump
//            o_clk_div_en  - enable strobe to the divider
//            o_clk_div_num - ratio presented to the divider
//            o_cur_div     - ratio currently committed
//            o_busy        - sequence in progress (includes the ack cycle)
//            o_ack         - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
    parameter int DIV_NUM_WD = 4,
    parameter int INI_DIV    = 1,
    parameter int EN_HOLD    = 4,
    parameter int SETTLE_CYC = 40
) (
    input  logic                  i_clk_ref,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    input  logic [DIV_NUM_WD-1:0] i_div_num,
    input  logic                  i_ramp,
    output logic                  o_clk_div_en,
    output logic [DIV_NUM_WD-1:0] o_clk_div_num,
    output logic [DIV_NUM_WD-1:0] o_cur_div,
    output logic                  o_busy,
    output logic                  o_ack
);

    // One counter serves both timed states, so it is sized for the longer one.
    localparam int c_MAX_CNT = (EN_HOLD > SETTLE_CYC) ? EN_HOLD : SETTLE_CYC;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);

    localparam logic [c_CNT_W-1:0]    c_EN_LAST     = c_CNT_W'(EN_HOLD - 1);
    localparam logic [c_CNT_W-1:0]    c_SETTLE_LAST = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [DIV_NUM_WD-1:0] c_INI_DIV     = DIV_NUM_WD'(INI_DIV);
    localparam logic [DIV_NUM_WD-1:0] c_DIV_ONE     = DIV_NUM_WD'(1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SETUP  = 3'd1;
    localparam logic [2:0] c_ST_EN     = 3'd2;
    localparam logic [2:0] c_ST_SETTLE = 3'd3;
    localparam logic [2:0] c_ST_ACK    = 3'd4;

    logic [2:0]            state_q,  state_d;
    logic [c_CNT_W-1:0]    cnt_q,    cnt_d;
    logic [DIV_NUM_WD-1:0] tgt_q,    tgt_d;
    logic                  ramp_q,   ramp_d;
    logic [DIV_NUM_WD-1:0] num_q,    num_d;
    logic [DIV_NUM_WD-1:0] cur_q,    cur_d;
    logic                  en_q;
    logic                  busy_q;
    logic                  ack_q;

    logic [DIV_NUM_WD-1:0] w_tgt_in;

    // Ratio 0 is not meaningful to the divider; treat it as divide-by-1.
    assign w_tgt_in = (i_div_num == '0) ? c_DIV_ONE : i_div_num;

    // Next ratio to present. Callers only use it when cur != tgt, so the
    // ramp branch never overshoots the target and never wraps.
    function automatic logic [DIV_NUM_WD-1:0] f_step(
        input logic [DIV_NUM_WD-1:0] cur,
        input logic [DIV_NUM_WD-1:0] tgt,
        input logic                  ramp
    );
        if (!ramp) begin
            return tgt;
        end else if (tgt > cur) begin
            return cur + c_DIV_ONE;
        end else if (tgt < cur) begin
            return cur - c_DIV_ONE;
        end else begin
            return cur;
        end
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        ramp_d  = ramp_q;
        num_d   = num_q;
        cur_d   = cur_q;
        case (state_q)
            c_ST_IDLE: begin
                if (i_req) begin
                    tgt_d  = w_tgt_in;
                    ramp_d = i_ramp;
                    if (w_tgt_in == cur_q) begin
                        state_d = c_ST_ACK;
                    end else begin
                        state_d = c_ST_SETUP;
                        num_d   = f_step(cur_q, w_tgt_in, i_ramp);
                    end
                end
            end
            c_ST_SETUP: begin
                state_d = c_ST_EN;
                cnt_d   = '0;
            end
            c_ST_EN: begin
                if (cnt_q == c_EN_LAST) begin
                    state_d = c_ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            c_ST_SETTLE: begin
                if (cnt_q == c_SETTLE_LAST) begin
                    cnt_d = '0;
                    // The presented ratio has settled; it is now committed.
                    cur_d = num_q;
                    if (num_q == tgt_q) begin
                        state_d = c_ST_ACK;
                    end else begin
                        state_d = c_ST_SETUP;
                        num_d   = f_step(num_q, tgt_q, ramp_q);
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            c_ST_ACK: begin
                state_d = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Status outputs are decoded from the next state and registered so they
    // line up with the state they describe without combinational paths.
    always_ff @(posedge i_clk_ref or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= c_ST_IDLE;
            cnt_q   <= '0;
            tgt_q   <= c_INI_DIV;
            ramp_q  <= 1'b0;
            num_q   <= c_INI_DIV;
            cur_q   <= c_INI_DIV;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            ramp_q  <= ramp_d;
            num_q   <= num_d;
            cur_q   <= cur_d;
            en_q    <= (state_d == c_ST_EN);
            busy_q  <= (state_d != c_ST_IDLE);
            ack_q   <= (state_d == c_ST_ACK);
        end
    end

    assign o_clk_div_en  = en_q;
    assign o_clk_div_num = num_q;
    assign o_cur_div     = cur_q;
    assign o_busy        = busy_q;
    assign o_ack         = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_ctrl
// Purpose  : Self-checking bench for clk_div_ctrl. A transaction-level model
//            expands each accepted request into its expected per-cycle
//            outputs (step list, enable window, commit points, ack) and
//            compares them against the design every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

    localparam int c_W      = 4;
    localparam int c_INI    = 1;
    localparam int c_EN     = 4;
    localparam int c_SETTLE = 40;
    localparam int c_STEP   = 1 + c_EN + c_SETTLE;
    localparam int c_BOUND  = 2000;

    logic           clk;
    logic           rst_n;
    logic           i_req;
    logic [c_W-1:0] i_div_num;
    logic           i_ramp;
    logic           o_clk_div_en;
    logic [c_W-1:0] o_clk_div_num;
    logic [c_W-1:0] o_cur_div;
    logic           o_busy;
    logic           o_ack;

    clk_div_ctrl #(
        .DIV_NUM_WD (c_W),
        .INI_DIV    (c_INI),
        .EN_HOLD    (c_EN),
        .SETTLE_CYC (c_SETTLE)
    ) u_dut (
        .i_clk_ref     (clk),
        .i_rst_n       (rst_n),
        .i_req         (i_req),
        .i_div_num     (i_div_num),
        .i_ramp        (i_ramp),
        .o_clk_div_en  (o_clk_div_en),
        .o_clk_div_num (o_clk_div_num),
        .o_cur_div     (o_cur_div),
        .o_busy        (o_busy),
        .o_ack         (o_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int num;
        int en;
        int cur;
        int busy;
        int ack;
    } exp_t;

    exp_t exp_q[$];
    int   exp_cur    = c_INI;
    int   exp_num    = c_INI;
    bit   model_busy = 1'b0;

    // Expand one accepted request into the expected output of every cycle
    // from the cycle after acceptance through the ack cycle.
    task automatic build(input int div, input bit ramp);
        int   tgt;
        int   v;
        int   prev;
        int   vals[$];
        exp_t e;
        tgt = (div == 0) ? 1 : div;
        if (tgt != exp_cur) begin
            if (ramp) begin
                v = exp_cur;
                while (v != tgt) begin
                    v = (tgt > v) ? v + 1 : v - 1;
                    vals.push_back(v);
                end
            end else begin
                vals.push_back(tgt);
            end
        end
        prev = exp_cur;
        foreach (vals[s]) begin
            for (int k = 0; k < c_STEP; k++) begin
                e.num  = vals[s];
                e.en   = (k >= 1 && k <= c_EN) ? 1 : 0;
                e.cur  = prev;
                e.busy = 1;
                e.ack  = 0;
                exp_q.push_back(e);
            end
            prev = vals[s];
        end
        if (vals.size() > 0) exp_num = prev;
        e.num  = exp_num;
        e.en   = 0;
        e.cur  = prev;
        e.busy = 1;
        e.ack  = 1;
        exp_q.push_back(e);
        exp_cur = prev;
    endtask

    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            exp_cur = c_INI;
            exp_num = c_INI;
        end else if (!model_busy && i_req) begin
            build(int'(i_div_num), i_ramp);
        end
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            model_busy = 1'b1;
        end else begin
            e.num  = exp_num;
            e.en   = 0;
            e.cur  = exp_cur;
            e.busy = 0;
            e.ack  = 0;
            model_busy = 1'b0;
        end
        check_val("en",   int'(o_clk_div_en),  e.en);
        check_val("num",  int'(o_clk_div_num), e.num);
        check_val("cur",  int'(o_cur_div),     e.cur);
        check_val("busy", int'(o_busy),        e.busy);
        check_val("ack",  int'(o_ack),         e.ack);
    end

    // ---------------- stimulus ----------------
    task automatic junk();
        i_req     = 1'($urandom_range(0, 1));
        i_div_num = c_W'($urandom);
        i_ramp    = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_gap(input int n);
        repeat (n) begin
            @(negedge clk);
            if (model_busy) junk();
            else i_req = 1'b0;
        end
    endtask

    // Waits (with noise on the inputs) for an idle cycle, then presents the
    // request for exactly that cycle. Returns mid-way through the SETUP cycle.
    task automatic issue(input int div, input bit ramp);
        int n = 0;
        @(negedge clk);
        while (model_busy && n < c_BOUND) begin
            junk();
            @(negedge clk);
            n++;
        end
        if (n >= c_BOUND) check_val("idle_timeout", 1, 0);
        i_req     = 1'b1;
        i_div_num = c_W'(div);
        i_ramp    = ramp;
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        i_req     = 1'b0;
        i_div_num = '0;
        i_ramp    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        issue(4, 1'b0);   // jump 1 -> 4
        issue(1, 1'b0);   // jump back to 1
        issue(4, 1'b1);   // ramp 1 -> 4
        issue(4, 1'b0);   // target equals current
        issue(1, 1'b1);   // ramp 4 -> 1
        issue(0, 1'b0);   // zero normalised to 1, equals current

        // Reset during the enable window of a jump to 4.
        issue(4, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        i_req = 1'b0;
        #1;
        check_val("rst_en",   int'(o_clk_div_en),  0);
        check_val("rst_num",  int'(o_clk_div_num), c_INI);
        check_val("rst_cur",  int'(o_cur_div),     c_INI);
        check_val("rst_busy", int'(o_busy),        0);
        check_val("rst_ack",  int'(o_ack),         0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(3, 1'b1);

        for (int r = 0; r < 25; r++) begin
            idle_gap($urandom_range(0, 3));
            issue($urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end

        n = 0;
        i_req = 1'b0;
        while (n < c_BOUND) begin
            @(negedge clk);
            i_req = 1'b0;
            if (!model_busy) break;
            n++;
        end
        if (n >= c_BOUND) check_val("drain_timeout", 1, 0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter DIV_NUM_WD, default 4, width of divide-ratio fields; SHALL match downstream divider.
REQ-002 Parameter INI_DIV, default 1, ratio the downstream divider holds after reset; SHALL be >= 1.
REQ-003 Parameter EN_HOLD, default 4, cycles o_clk_div_en is held high per update step; SHALL be >= 3.
REQ-004 Parameter SETTLE_CYC, default 40, wait cycles after en deassert per step; SHALL be >= 2*2^DIV_NUM_WD+4.
REQ-005 One clock; reset is asynchronous and active-low: i_clk_ref, i_rst_n.
REQ-006 i_clk_ref  input  1  reference clock, same clock as the downstream divider.
REQ-007 i_rst_n  input  1  asynchronous active-low reset.
REQ-008 i_req  input  1  level; a request is accepted when high in IDLE.
REQ-009 i_div_num  input  DIV_NUM_WD  target ratio, sampled on acceptance.
REQ-010 i_ramp  input  1  sampled on acceptance; 1 = step ratio by 1 per update, 0 = single jump.
REQ-011 o_clk_div_en  output  1  enable strobe to divider.
REQ-012 o_clk_div_num  output  DIV_NUM_WD  ratio to divider.
REQ-013 o_cur_div  output  DIV_NUM_WD  ratio currently committed.
REQ-014 o_busy  output  1  sequence in progress.
REQ-015 o_ack  output  1  one-cycle completion pulse.

Function
REQ-016 FSM states IDLE, SETUP, EN, SETTLE, ACK; all outputs registered.
REQ-017 IDLE: on i_req=1, capture target (0 normalized to 1) and ramp flag; next state SETUP, or ACK if target == o_cur_div.
REQ-018 Step value: ramp=1 -> o_cur_div +1 or -1 toward target; ramp=0 -> target.
REQ-019 SETUP lasts 1 cycle; o_clk_div_num takes step value on entry and holds it until the next SETUP entry.
REQ-020 EN lasts EN_HOLD cycles with o_clk_div_en=1; o_clk_div_en is 0 in all other states.
REQ-021 SETTLE lasts SETTLE_CYC cycles; on exit o_cur_div <= step value, then ACK if equal to target, else SETUP.
REQ-022 ACK lasts 1 cycle with o_ack=1, then IDLE.
REQ-023 o_busy=1 in every non-IDLE state, including ACK; 0 in IDLE.
REQ-024 i_req, i_div_num, i_ramp are ignored outside IDLE; no queueing; i_req still high on return to IDLE starts a new request.
REQ-025 Counter sized for max(EN_HOLD, SETTLE_CYC); it SHALL not wrap within a state.
REQ-026 Ratio arithmetic is unsigned DIV_NUM_WD-bit; ramp never passes the target and never wraps.

Reset
REQ-027 Reset asserted: state IDLE, o_clk_div_en=0, o_busy=0, o_ack=0, o_clk_div_num=INI_DIV, o_cur_div=INI_DIV, counter 0.
REQ-028 Reset mid-sequence aborts with no ack pulse; o_cur_div returns to INI_DIV.

Verification
REQ-029 W=4, INI_DIV=1, EN_HOLD=4, SETTLE_CYC=40, i_req high at cycle t, target 4, ramp 0 -> busy=1 and num=4 at t+1; en=1 for t+2..t+5; ack at t+46; busy=0 at t+47; cur_div=4.
REQ-030 From cur 1, target 4, ramp 1 -> num sequence 2, 3, 4; three en pulses of 4 cycles each; ack at t+136.
REQ-031 Target equal to cur_div, or target 0 with cur 1 -> ack and busy at t+1 only; en never asserts.
REQ-032 From cur 4, target 1, ramp 1 -> num sequence 3, 2, 1; ratio values stay in 1..4.
REQ-033 Toggle i_req and i_div_num during SETTLE -> no effect on num or timing; i_req held high through ACK -> new acceptance on the first IDLE cycle.
REQ-034 Assert i_rst_n=0 during EN -> en=0 at once, num=cur_div=1, no ack; after release, a new request completes normally.
